mailbox_enq_arbiter: RTL and testbench
======================================

Name: mailbox_enq_arbiter

Overview:
- Round-robin arbiter that shares the write (enq) side of a single-entry asynchronous mailbox among N requesters in the w_clock domain.
- Supports multi-beat messages: a grant is locked to one requester until it sends a last beat, or until MAX_BURST beats have been sent.
- Registers each winning beat, prefixes it with the requester ID, and presents it to the mailbox enq port with a valid/ready handshake.
- Sits between the producer clients and the mailbox. The read-side consumer decodes the ID field.

Parameters:
- N, 4, number of requesters (>=2).
- WIDTH, 32, payload width per requester.
- IDW, $clog2(N), width of the requester ID field.
- MAX_BURST, 8, maximum beats per locked grant (>=1). A value of 1 disables locking.

Ports:
- w_clock  in  1  write-domain clock.
- w_reset  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-requester beat valid.
- req_last  in  N  per-requester last-beat-of-message flag.
- req_bits  in  N*WIDTH  per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N  per-requester accept; at most one bit high per cycle.
- enq_valid  out  1  to mailbox enq_valid.
- enq_ready  in  1  from mailbox enq_ready.
- enq_bits  out  IDW+WIDTH  {id, payload} to mailbox enq_bits.
- grant_id  out  IDW  ID of the current or last winner.
- locked  out  1  high while a multi-beat grant is held.

Behaviour:
- Reset values (w_reset asynchronous, active-high; clock w_clock): enq_valid=0, enq_bits=0, req_ready=0, grant_id=N-1 (so requester 0 has first priority), locked=0, burst count=0, state=ARB.
- Output stage: one register holding {out_valid, out_id, out_payload}. enq_valid=out_valid; enq_bits={out_id, out_payload}.
- can_load = !out_valid | enq_ready. Back-to-back loading in the same cycle as an enq fire is allowed.
- ARB state:
  - If can_load and any req_valid, choose winner w = first set req_valid scanning grant_id+1, grant_id+2, ... modulo N.
  - req_ready[w]=1 combinationally in that cycle. Beat accepted; output register loaded next edge; grant_id<=w.
  - If req_last[w]=0 and MAX_BURST>1: go to LOCKED with count<=1.
  - Otherwise stay in ARB.
- LOCKED state:
  - Only requester grant_id is eligible. req_ready[grant_id]=can_load. All other req_ready are 0, even if the locked requester is idle.
  - On an accepted beat: count<=count+1.
  - Return to ARB when the accepted beat has req_last=1, or when count+1==MAX_BURST (forced release). In either case clear count.
  - locked=1 only in LOCKED.
- Latency: a beat accepted at edge k has enq_valid=1 after edge k. Minimum of one cycle from request to mailbox.
- Handshake rules:
  - enq_valid and enq_bits are held stable until enq_ready. Never drop or alter a presented beat.
  - req_ready does not depend on req_valid of the same requester, except for winner selection in ARB.
- Fairness: grant_id updates only on an ARB win. A locked burst therefore counts as a single turn.
- Boundary conditions:
  - All requesters idle in ARB: no change.
  - enq_ready low (mailbox full): can_load=0, all req_ready=0, arbitration stalls, pointer frozen.
  - Simultaneous enq fire and new accept: the register is overwritten with the new beat in that cycle, and out_valid stays 1.
  - N not a power of two: the round-robin wrap uses modulo N, and IDs >= N are never produced.
  - Asynchronous reset mid-burst: an in-flight output beat is discarded, the lock is cleared, and the pointer returns to N-1.

Decomposition:
- Shared package mailbox_pkg holds:
  - state enum {ARB, LOCKED};
  - function rr_pick(valid vector, last pointer) returning index and found flag.
- One natural sub-module: rr_priority_picker, combinational, parameterised by N. It is reused by the read-side demux.

Test Plan:
- Reset, then requesters 0 and 2 valid with last=1 and enq_ready held 1 -> enq_bits IDs alternate 0,2,0,2 on consecutive cycles, starting one cycle after the first accept.
- enq_ready=0 for 5 cycles with all requesters valid -> all req_ready=0, enq_bits stable, grant_id unchanged; on release the next beat is loaded the same cycle as the fire.
- Requester 1 sends a 3-beat message (last on beat 3) while requester 3 is valid -> beats 1,1,1 appear, then 3; locked=1 for exactly the cycles spanning the burst.
- MAX_BURST=8 and requester 0 holds last=0 for 10 beats -> forced release after beat 8; requester 1 wins next; requester 0 resumes later in ARB.
- Assert w_reset asynchronously mid-burst with out_valid=1 -> enq_valid=0 immediately, locked=0, and first post-reset winner is the lowest valid ID.
- N=3 with all requesters valid -> IDs cycle 0,1,2,0; ID 3 never appears.

Source files
------------

// File: rtl/mailbox_enq_arbiter_pkg.sv
// Shared types and the round-robin search used by both sides of the mailbox.
package mailbox_pkg;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan last+1, last+2, ... wrapping at n; the first set bit wins.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                       input int unsigned n,
                                       input int unsigned last);
    rr_pick_t    res;
    int unsigned idx;
    res.found = 1'b0;
    res.idx   = '0;
    idx       = last;
    for (int unsigned k = 32'd0; k < RR_MAX_N; k++) begin
      if (k < n) begin
        idx = (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
        if (valid[idx[RR_IDX_W-1:0]] && !res.found) begin
          res.found = 1'b1;
          res.idx   = idx[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mailbox_enq_arbiter_if.sv
// Requester and mailbox-enq bundle; master is the arbiter, slave is its environment.
interface mailbox_enq_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N)
);
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_last;
  logic [N*WIDTH-1:0]   req_bits;
  logic [N-1:0]         req_ready;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [IDW+WIDTH-1:0] enq_bits;
  logic [IDW-1:0]       grant_id;
  logic                 locked;

  modport master (
    input  req_valid, req_last, req_bits, enq_ready,
    output req_ready, enq_valid, enq_bits, grant_id, locked
  );

  modport slave (
    output req_valid, req_last, req_bits, enq_ready,
    input  req_ready, enq_valid, enq_bits, grant_id, locked
  );
endinterface

// File: rtl/mailbox_enq_arbiter_picker.sv
// Combinational round-robin picker; also used by the read-side demux.
module rr_priority_picker
  import mailbox_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] idx_o,
  output logic           found_o
);

  logic [RR_MAX_N-1:0] valid_ext_s;
  rr_pick_t            pick_s;

  // Widen the request vector and run the shared search.
  always_comb begin
    valid_ext_s         = '0;
    valid_ext_s[N-1:0]  = valid_i;
    pick_s              = rr_pick(valid_ext_s, int'(N), 32'(ptr_i));
    idx_o               = IDW'(pick_s.idx);
    found_o             = pick_s.found;
  end

endmodule

// File: rtl/mailbox_enq_arbiter.sv
// Round-robin, burst-locking arbiter feeding the enq side of a one-entry mailbox.
module mailbox_enq_arbiter
  import mailbox_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int IDW       = $clog2(N),
  parameter int MAX_BURST = 8
) (
  input  logic                  w_clock,
  input  logic                  w_reset,
  mailbox_enq_arbiter_if.master bus
);

  localparam int CNTW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  arb_state_e       state_q;
  logic [CNTW-1:0]  count_q;
  logic [CNTW-1:0]  count_d;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   out_id_q;
  logic [WIDTH-1:0] out_payload_q;
  logic             out_valid_q;
  logic             locked_q;

  logic             can_load_s;
  logic             accept_s;
  logic             pick_found_s;
  logic             win_last_s;
  logic             burst_end_s;
  logic [IDW-1:0]   pick_idx_s;
  logic [IDW-1:0]   win_id_s;
  logic [N-1:0]     req_ready_s;
  logic [WIDTH-1:0] win_bits_s;

  rr_priority_picker #(.N(N), .IDW(IDW)) u_picker (
    .valid_i (bus.req_valid),
    .ptr_i   (grant_id_q),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // Winner selection and accept strobe; a locked grant offers ready even when idle.
  always_comb begin
    can_load_s  = !out_valid_q || bus.enq_ready;
    req_ready_s = '0;
    accept_s    = 1'b0;
    win_id_s    = grant_id_q;
    case (state_q)
      ARB: begin
        if (can_load_s && pick_found_s) begin
          win_id_s                = pick_idx_s;
          accept_s                = 1'b1;
          req_ready_s[pick_idx_s] = 1'b1;
        end else begin
          win_id_s = grant_id_q;
        end
      end
      LOCKED: begin
        req_ready_s[grant_id_q] = can_load_s;
        accept_s                = can_load_s && bus.req_valid[grant_id_q];
      end
      default: begin
        req_ready_s = '0;
        accept_s    = 1'b0;
      end
    endcase
    win_bits_s = '0;
    for (int i = 0; i < N; i++) begin
      if (win_id_s == IDW'(i)) begin
        win_bits_s = bus.req_bits[i*WIDTH +: WIDTH];
      end else begin
        win_bits_s = win_bits_s;
      end
    end
    win_last_s  = bus.req_last[win_id_s];
    count_d     = count_q + CNTW'(1);
    burst_end_s = win_last_s || (count_d == CNTW'(MAX_BURST));
  end

  // Output register and grant FSM.
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_payload_q <= '0;
      grant_id_q    <= IDW'(N - 1);
      count_q       <= '0;
      locked_q      <= 1'b0;
      state_q       <= ARB;
    end else begin
      if (accept_s) begin
        out_valid_q   <= 1'b1;
        out_id_q      <= win_id_s;
        out_payload_q <= win_bits_s;
      end else if (bus.enq_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ARB: begin
          if (accept_s) begin
            grant_id_q <= win_id_s;
            if (!win_last_s && (MAX_BURST > 1)) begin
              state_q  <= LOCKED;
              count_q  <= CNTW'(1);
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (accept_s) begin
            if (burst_end_s) begin
              state_q  <= ARB;
              count_q  <= '0;
              locked_q <= 1'b0;
            end else begin
              count_q <= count_d;
            end
          end
        end
        default: begin
          state_q  <= ARB;
          count_q  <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.enq_valid = out_valid_q;
  assign bus.enq_bits  = {out_id_q, out_payload_q};
  assign bus.grant_id  = grant_id_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_mailbox_enq_arbiter.sv
// Directed scoreboard bench: a 4-requester and a 3-requester arbiter instance.
module tb_mailbox_enq_arbiter;

  logic w_clock = 1'b0;
  logic w_reset;
  int   errors = 0;
  int   checks = 0;

  logic [33:0] sb4[$];
  logic [33:0] sb3[$];
  logic [23:0] seq4 [4];

  always #5 w_clock = ~w_clock;

  mailbox_enq_arbiter_if #(.N(4), .WIDTH(32), .IDW(2)) bus4 ();
  mailbox_enq_arbiter_if #(.N(3), .WIDTH(32), .IDW(2)) bus3 ();

  mailbox_enq_arbiter #(.N(4), .WIDTH(32), .IDW(2), .MAX_BURST(8)) dut4 (
    .w_clock (w_clock),
    .w_reset (w_reset),
    .bus     (bus4)
  );

  mailbox_enq_arbiter #(.N(3), .WIDTH(32), .IDW(2), .MAX_BURST(8)) dut3 (
    .w_clock (w_clock),
    .w_reset (w_reset),
    .bus     (bus3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh4();
    for (int i = 0; i < 4; i++) bus4.req_bits[i*32 +: 32] = {4'hA, 4'(i), seq4[i]};
  endtask

  // One cycle on dut4: inputs already driven at the preceding negedge.
  task automatic cyc4(input logic [3:0] exp_rdy, input logic exp_lk, input string tag);
    logic [3:0]  acc;
    logic [33:0] front;
    refresh4();
    #1;
    chk({tag, " rdy"}, 64'(bus4.req_ready), 64'(exp_rdy));
    chk({tag, " locked"}, 64'(bus4.locked), 64'(exp_lk));
    if (bus4.enq_valid === 1'b1 && bus4.enq_ready === 1'b1) begin
      if (sb4.size() == 0) begin
        chk({tag, " unexpected beat"}, 64'(sb4.size()), 64'd1);
      end else begin
        front = sb4.pop_front();
        chk({tag, " enq_bits"}, 64'(bus4.enq_bits), 64'(front));
      end
    end
    acc = exp_rdy & bus4.req_valid;
    for (int i = 0; i < 4; i++)
      if (acc[i]) sb4.push_back({2'(i), bus4.req_bits[i*32 +: 32]});
    @(posedge w_clock);
    for (int i = 0; i < 4; i++)
      if (acc[i]) seq4[i] = seq4[i] + 24'd1;
    @(negedge w_clock);
  endtask

  // One cycle on dut3 with constant per-requester payloads.
  task automatic cyc3(input logic [2:0] exp_rdy, input string tag);
    logic [2:0]  acc;
    logic [33:0] front;
    #1;
    chk({tag, " rdy"}, 64'(bus3.req_ready), 64'(exp_rdy));
    if (bus3.enq_valid === 1'b1 && bus3.enq_ready === 1'b1) begin
      if (sb3.size() == 0) begin
        chk({tag, " unexpected beat"}, 64'(sb3.size()), 64'd1);
      end else begin
        front = sb3.pop_front();
        chk({tag, " enq_bits"}, 64'(bus3.enq_bits), 64'(front));
      end
    end
    acc = exp_rdy & bus3.req_valid;
    for (int i = 0; i < 3; i++)
      if (acc[i]) sb3.push_back({2'(i), bus3.req_bits[i*32 +: 32]});
    @(posedge w_clock);
    @(negedge w_clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) seq4[i] = 24'd0;
    w_reset         = 1'b1;
    bus4.req_valid  = 4'b0000;
    bus4.req_last   = 4'b0000;
    bus4.enq_ready  = 1'b1;
    refresh4();
    bus3.req_valid  = 3'b000;
    bus3.req_last   = 3'b000;
    bus3.enq_ready  = 1'b1;
    for (int i = 0; i < 3; i++) bus3.req_bits[i*32 +: 32] = 32'hC000_0000 + 32'(i);

    // Reset state.
    #2;
    chk("reset enq_valid", 64'(bus4.enq_valid), 64'd0);
    chk("reset enq_bits", 64'(bus4.enq_bits), 64'd0);
    chk("reset req_ready", 64'(bus4.req_ready), 64'd0);
    chk("reset grant_id", 64'(bus4.grant_id), 64'd3);
    chk("reset locked", 64'(bus4.locked), 64'd0);
    @(negedge w_clock);
    w_reset = 1'b0;

    // Requesters 0 and 2, single-beat messages: alternate 0,2,0,2.
    bus4.req_valid = 4'b0101;
    bus4.req_last  = 4'b1111;
    for (int k = 0; k < 6; k++) cyc4((k % 2 == 0) ? 4'b0001 : 4'b0100, 1'b0, "alt");
    chk("alt grant_id", 64'(bus4.grant_id), 64'd2);

    // Mailbox full for 5 cycles with every requester valid.
    bus4.req_valid = 4'b1111;
    bus4.enq_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc4(4'b0000, 1'b0, "stall");
      chk("stall grant_id", 64'(bus4.grant_id), 64'd2);
      chk("stall enq_valid", 64'(bus4.enq_valid), 64'd1);
      chk("stall enq_bits", 64'(bus4.enq_bits), 64'(sb4[0]));
    end
    bus4.enq_ready = 1'b1;
    cyc4(4'b1000, 1'b0, "unstall");
    chk("unstall reload valid", 64'(bus4.enq_valid), 64'd1);
    chk("unstall reload bits", 64'(bus4.enq_bits), 64'(sb4[0]));

    // Requester 1 sends a 3-beat message, with an idle gap, while 3 waits.
    bus4.req_valid = 4'b1010; bus4.req_last = 4'b1000;
    cyc4(4'b0010, 1'b0, "burst b1");
    cyc4(4'b0010, 1'b1, "burst b2");
    bus4.req_valid = 4'b1000;
    cyc4(4'b0010, 1'b1, "burst idle");
    bus4.req_valid = 4'b1010; bus4.req_last = 4'b1010;
    cyc4(4'b0010, 1'b1, "burst b3");
    bus4.req_valid = 4'b1000; bus4.req_last = 4'b1000;
    cyc4(4'b1000, 1'b0, "burst after");

    // Requester 0 never ends its message: forced release after 8 beats.
    bus4.req_valid = 4'b0011; bus4.req_last = 4'b0010;
    cyc4(4'b0001, 1'b0, "force b1");
    for (int k = 2; k <= 8; k++) cyc4(4'b0001, 1'b1, "force bn");
    cyc4(4'b0010, 1'b0, "force next");
    cyc4(4'b0001, 1'b0, "force resume");
    bus4.req_last = 4'b0011;
    cyc4(4'b0001, 1'b1, "force end");
    bus4.req_valid = 4'b0000;
    cyc4(4'b0000, 1'b0, "force idle");

    // Asynchronous reset in the middle of a burst with a beat presented.
    bus4.req_valid = 4'b0100; bus4.req_last = 4'b0000;
    cyc4(4'b0100, 1'b0, "rst b1");
    cyc4(4'b0100, 1'b1, "rst b2");
    #2;
    w_reset = 1'b1;
    #1;
    chk("async enq_valid", 64'(bus4.enq_valid), 64'd0);
    chk("async enq_bits", 64'(bus4.enq_bits), 64'd0);
    chk("async locked", 64'(bus4.locked), 64'd0);
    chk("async grant_id", 64'(bus4.grant_id), 64'd3);
    sb4.delete();
    bus4.req_valid = 4'b1110; bus4.req_last = 4'b1111;
    @(negedge w_clock);
    w_reset = 1'b0;
    cyc4(4'b0010, 1'b0, "post0");
    cyc4(4'b0100, 1'b0, "post1");
    bus4.req_valid = 4'b0000;
    cyc4(4'b0000, 1'b0, "post2");
    chk("sb4 drained", 64'(sb4.size()), 64'd0);

    // Three requesters, all valid: 0,1,2,0,1,2 and never ID 3.
    bus3.req_valid = 3'b111; bus3.req_last = 3'b111;
    for (int k = 0; k < 6; k++) cyc3(3'(1 << (k % 3)), "n3");
    bus3.req_valid = 3'b000;
    cyc3(3'b000, "n3 idle");
    chk("sb3 drained", 64'(sb3.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
